tri_bus_arbiter: RTL and testbench
==================================

// Module: tri_bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for a shared tri-state net driven by NUM_REQ
//  requesters. Issues one-hot drive enables and inserts a turnaround cycle
//  between owners, so at most one driver is ever active. Enforces a max hold.
//  Models a trireg-style keeper: last driven value held for CHARGE_CYCLES idle cycles, then decays.
// PARAMETERS
//  NUM_REQ        4   number of requesters (>=2)
//  DATA_W         8   bus data width
//  MAX_HOLD       16  max consecutive OWN cycles per grant (>=1)
//  CHARGE_CYCLES  8   undriven cycles keeper holds value (>=1)
// PORTS
//  clk           in   1                one clock, all logic on posedge
//  reset         in   1                asynchronous, active-high
//  req           in   NUM_REQ          request, held high while bus wanted
//  req_data      in   NUM_REQ*DATA_W   requester i data at [i*DATA_W +: DATA_W]
//  grant         out  NUM_REQ          registered one-hot grant (0 when no owner)
//  drive_en      out  NUM_REQ          tri-state enables; equals grant, only in OWN
//  owner         out  $clog2(NUM_REQ)  index of current/last owner
//  bus_data      out  DATA_W           resolved bus value
//  bus_valid     out  1                bus actively driven this cycle
//  keeper_valid  out  1                undriven, keeper still holds charge
//  timeout       out  1                1-cycle pulse: grant revoked at MAX_HOLD
// BEHAVIOUR
//  Reset (async): state=IDLE, grant=0, drive_en=0, owner=NUM_REQ-1,
//   bus_data=0, bus_valid=0, keeper_valid=0, timeout=0, hold_cnt=0, charge_cnt=0.
//  States: IDLE, OWN, TURN.
//  Arbitration (IDLE or TURN): winner = first i with req[i]=1, searching
//   owner+1, owner+2, ... mod NUM_REQ. Last owner is lowest priority.
//  IDLE: any req -> OWN next cycle; grant=onehot(winner), owner=winner,
//   hold_cnt=0. Latency req->grant = 1 cycle. No req -> stay IDLE.
//  OWN: drive_en=grant, bus_valid=1, bus_data=req_data[owner] (combinational).
//   keeper register loads bus_data every OWN cycle. hold_cnt increments.
//   req[owner]=0 at edge -> TURN, grant=0.
//   Else hold_cnt==MAX_HOLD-1 -> TURN, grant=0, timeout=1 for one cycle.
//   Req drop wins when both occur on the same edge (no timeout pulse).
//   Changes on other req bits while in OWN are ignored.
//  TURN: exactly 1 cycle, grant=0, drive_en=0, bus_valid=0.
//   Arbitrates as IDLE: any req -> OWN, else -> IDLE.
//   A timed-out owner still requesting re-wins only if no one else requests.
//  Keeper: charge_cnt loads CHARGE_CYCLES on every OWN cycle.
//   It decrements each non-OWN cycle, saturating at 0.
//   keeper_valid = !OWN && charge_cnt!=0.
//   bus_data = keeper when keeper_valid; 0 when neither driven nor charged.
//  Invariant: popcount(drive_en)<=1 always. drive_en never 1 in IDLE or TURN.
//  grant, drive_en and timeout are registered. bus_data mux is combinational on req_data.
// TESTING
//  1 After reset, req=0 for 20 cycles -> grant=0, bus_valid=0,
//    keeper_valid=0, bus_data=0.
//  2 req=4'b0001, data0=8'hA5 for 3 cycles then drop -> grant=0001 one
//    cycle after req. bus_data=A5 while owned. Then TURN (keeper_valid=1,
//    bus_data=A5) for 8 cycles, then keeper_valid=0, bus_data=0.
//  3 req=4'b1111 held constantly, each drops after 2 OWN cycles then
//    re-raises -> grant order 0001,0010,0100,1000,0001. A zero-grant TURN
//    cycle sits between every pair. drive_en popcount<=1 throughout.
//  4 req=4'b0010 held for 40 cycles, alone -> timeout pulses after
//    16 OWN cycles, then TURN, then requester 1 re-granted. With req[2]
//    also high, grant moves to 0100 after TURN.
//  5 Same-edge drop: req[owner] falls on the edge where hold_cnt==15 ->
//    TURN, timeout stays 0.
//  6 reset asserted mid-OWN (async, between edges) -> grant, drive_en,
//    bus_valid, keeper_valid go 0 immediately. After release, req[0]
//    wins first (owner reset to 3).

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state net: one-hot drive enables,
// a dead turnaround cycle between owners, a hold limit and a decaying charge keeper.
module tri_bus_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int MAX_HOLD      = 16,
    parameter int CHARGE_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          drive_en,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic [DATA_W-1:0]           bus_data,
    output logic                        bus_valid,
    output logic                        keeper_valid,
    output logic                        timeout
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int CW = $clog2(CHARGE_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST   = HW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] CHARGE_FULL = CW'(CHARGE_CYCLES);
    localparam logic [OW-1:0] OWNER_RST   = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [CW-1:0]     charge_cnt;
    logic [DATA_W-1:0] keeper;

    // Search starts just after the last owner, so the last owner ranks lowest.
    // Result is {found, index}.
    function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      last);
        logic          found;
        logic [OW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && r[OW'(cand)]) begin
                found = 1'b1;
                idx   = OW'(cand);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    logic [OW:0]       pick;
    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic              own_active;
    logic [DATA_W-1:0] owner_data;

    assign pick       = rr_pick(req, owner);
    assign pick_found = pick[OW];
    assign pick_idx   = pick[OW-1:0];
    assign own_active = (state == OWN);
    assign owner_data = req_data[owner*DATA_W +: DATA_W];

    assign bus_valid    = own_active;
    assign keeper_valid = !own_active && (charge_cnt != '0);

    always_comb begin
        bus_data = '0;
        if (own_active)
            bus_data = owner_data;
        else if (keeper_valid)
            bus_data = keeper;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            drive_en   <= '0;
            owner      <= OWNER_RST;
            hold_cnt   <= '0;
            charge_cnt <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (charge_cnt != '0)
                        charge_cnt <= charge_cnt - 1'b1;
                    if (pick_found) begin
                        state    <= OWN;
                        grant    <= onehot(pick_idx);
                        drive_en <= onehot(pick_idx);
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN: begin
                    charge_cnt <= CHARGE_FULL;
                    // A dropped request takes precedence over the hold limit.
                    if (!req[owner]) begin
                        state    <= TURN;
                        grant    <= '0;
                        drive_en <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= TURN;
                        grant    <= '0;
                        drive_en <= '0;
                        timeout  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    drive_en <= '0;
                end
            endcase
        end
    end

    // The keeper only ever shows a value that was really on the net.
    always_ff @(posedge clk) begin
        if (own_active)
            keeper <= owner_data;
    end

    a_single_driver: assert property (@(posedge clk) disable iff (reset)
        $onehot0(drive_en));
    a_drive_only_in_own: assert property (@(posedge clk) disable iff (reset)
        (state != OWN) |-> (drive_en == '0));
    a_drive_matches_grant: assert property (@(posedge clk) disable iff (reset)
        drive_en == grant);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: a stimulus table, directed corner sequences and a
// long random run, all compared against an ownership-level reference model.
module tb_tri_bus_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 8;
    localparam int MAX_HOLD      = 16;
    localparam int CHARGE_CYCLES = 8;

    logic                       clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         drive_en;
    logic [1:0]                 owner;
    logic [DATA_W-1:0]          bus_data;
    logic                       bus_valid;
    logic                       keeper_valid;
    logic                       timeout;

    int vectors;
    int miscompares;

    tri_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
        .MAX_HOLD(MAX_HOLD), .CHARGE_CYCLES(CHARGE_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .drive_en(drive_en), .owner(owner),
        .bus_data(bus_data), .bus_valid(bus_valid),
        .keeper_valid(keeper_valid), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the net, for how many cycles so far, and how
    // many undriven cycles have passed since the last value was put on it.
    bit         m_owned;
    int         m_cur;
    int         m_last;
    int         m_len;
    bit         m_to;
    int         m_idle;
    logic [7:0] m_val;

    function automatic void m_reset();
        m_owned = 0;
        m_cur   = 0;
        m_last  = NUM_REQ - 1;
        m_len   = 0;
        m_to    = 0;
        m_idle  = CHARGE_CYCLES;
        m_val   = 8'h00;
    endfunction

    function automatic int m_pick(input logic [NUM_REQ-1:0] r);
        int order[$];
        for (int k = 1; k <= NUM_REQ; k++) order.push_back((m_last + k) % NUM_REQ);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] d, input int i);
        return d[i*DATA_W +: DATA_W];
    endfunction

    function automatic void m_step(input logic [NUM_REQ-1:0] r, input logic [31:0] d);
        bit nxt_to;
        int w;
        nxt_to = 0;
        if (m_owned) begin
            m_val  = lane(d, m_cur);
            m_idle = 0;
            if (!r[m_cur]) m_owned = 0;
            else if (m_len == MAX_HOLD) begin
                m_owned = 0;
                nxt_to  = 1;
            end else m_len++;
        end else begin
            if (m_idle < CHARGE_CYCLES) m_idle++;
            w = m_pick(r);
            if (w >= 0) begin
                m_owned = 1;
                m_cur   = w;
                m_last  = w;
                m_len   = 1;
            end
        end
        m_to = nxt_to;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        logic       ekv;
        logic [7:0] ebd;
        eg  = m_owned ? 4'(1 << m_cur) : 4'h0;
        ekv = !m_owned && (m_idle < CHARGE_CYCLES);
        ebd = m_owned ? lane(req_data, m_cur) : (ekv ? m_val : 8'h00);
        chk("grant", 32'(grant), 32'(eg));
        chk("drive_en", 32'(drive_en), 32'(eg));
        chk("owner", 32'(owner), 32'(m_last));
        chk("bus_valid", 32'(bus_valid), 32'(m_owned));
        chk("keeper_valid", 32'(keeper_valid), 32'(ekv));
        chk("bus_data", 32'(bus_data), 32'(ebd));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("drive_onehot", 32'($countones(drive_en) <= 1), 32'd1);
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] r, input logic [31:0] d);
        @(negedge clk);
        req      = r;
        req_data = d;
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_step(req, req_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic [3:0] r;
        logic [7:0] d0;
        logic [3:0] g;
        logic       bv;
        logic       kv;
        logic [7:0] bd;
    } vec_t;

    vec_t tbl[14];
    logic [3:0] order_q[$];
    logic [3:0] exp_order[5];
    logic [3:0] prev_g;
    logic [3:0] rr;
    int quiet;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = '0;
        req_data    = '0;
        m_reset();

        tbl[0] = '{4'b0001, 8'hA5, 4'b0000, 1'b0, 1'b0, 8'h00};
        for (int i = 1; i <= 3; i++) tbl[i] = '{4'b0001, 8'hA5, 4'b0001, 1'b1, 1'b0, 8'hA5};
        tbl[4] = '{4'b0000, 8'hA5, 4'b0001, 1'b1, 1'b0, 8'hA5};
        for (int i = 5; i <= 12; i++) tbl[i] = '{4'b0000, 8'h3C, 4'b0000, 1'b0, 1'b1, 8'hA5};
        tbl[13] = '{4'b0000, 8'h3C, 4'b0000, 1'b0, 1'b0, 8'h00};

        // Quiet bus after reset
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(4'b0000, 32'h1234_5678);
            chk("quiet_grant", 32'(grant), 32'd0);
            chk("quiet_bus_data", 32'(bus_data), 32'd0);
            advance();
        end

        // Single owner then keeper decay, from the table
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].r, {24'h5A_C3_99, tbl[i].d0});
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_bus_valid", i), 32'(bus_valid), 32'(tbl[i].bv));
            chk($sformatf("tbl%0d_keeper_valid", i), 32'(keeper_valid), 32'(tbl[i].kv));
            chk($sformatf("tbl%0d_bus_data", i), 32'(bus_data), 32'(tbl[i].bd));
            advance();
        end

        // Round-robin rotation with each owner dropping after two cycles
        do_reset();
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        order_q.delete();
        prev_g = '0;
        for (int c = 0; c < 40 && order_q.size() < 5; c++) begin
            rr = 4'b1111;
            if (m_owned && m_len == 2) rr[m_cur] = 1'b0;
            drive(rr, $urandom);
            if (grant != 0 && prev_g == 0) order_q.push_back(grant);
            prev_g = grant;
            advance();
        end
        chk("rr_grants_seen", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < order_q.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

        // Hold limit: lone requester re-wins, then loses to a newcomer
        do_reset();
        for (int c = 0; c < 40; c++) begin
            drive((c >= 19) ? 4'b0110 : 4'b0010, $urandom);
            if (c == 16) chk("hold_no_early_timeout", 32'(timeout), 32'd0);
            if (c == 17) begin
                chk("hold_timeout1", 32'(timeout), 32'd1);
                chk("hold_turn_grant", 32'(grant), 32'd0);
            end
            if (c == 18) chk("hold_regrant", 32'(grant), 32'b0010);
            if (c == 34) chk("hold_timeout2", 32'(timeout), 32'd1);
            if (c == 35) chk("hold_handover", 32'(grant), 32'b0100);
            advance();
        end

        // Request drop on the same edge as the hold limit
        do_reset();
        for (int c = 0; c < 18; c++) begin
            drive((c < 16) ? 4'b0001 : 4'b0000, $urandom);
            if (c == 17) begin
                chk("same_edge_timeout", 32'(timeout), 32'd0);
                chk("same_edge_grant", 32'(grant), 32'd0);
            end
            advance();
        end

        // Asynchronous reset in the middle of an ownership
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0001, 32'h0000_00E7);
            advance();
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_drive_en", 32'(drive_en), 32'd0);
        chk("async_bus_valid", 32'(bus_valid), 32'd0);
        chk("async_keeper_valid", 32'(keeper_valid), 32'd0);
        chk("async_bus_data", 32'(bus_data), 32'd0);
        chk("async_owner", 32'(owner), 32'd3);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, $urandom);
        advance();
        drive(4'b1111, $urandom);
        chk("post_reset_first_winner", 32'(grant), 32'b0001);
        advance();

        // Random traffic against the model
        do_reset();
        rr    = '0;
        quiet = 0;
        for (int c = 0; c < 3000; c++) begin
            if (quiet > 0) begin
                quiet--;
                rr = '0;
            end else if ($urandom_range(0, 199) == 0) begin
                quiet = 12;
                rr    = '0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++)
                    if ($urandom_range(0, 9) == 0) rr[i] = ~rr[i];
            end
            drive(rr, $urandom);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
